// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller: mode encodings,
// speed divisor table and the LED pattern constants.
package led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  // Number of extra base ticks between steps for speed 0 / 1 / 2
  localparam logic [1:0] SPEED_DIV [3] = '{2'd3, 2'd1, 2'd0};

  localparam logic [3:0] PAT_FIRST = 4'b0001;
  localparam logic [3:0] PAT_LAST  = 4'b1000;
  localparam logic [3:0] PAT_ALL   = 4'b1111;
  localparam logic [3:0] PAT_NONE  = 4'b0000;

  // Divisor for a speed level; level 3 is never produced, treat it as fastest
  function automatic logic [1:0] speed_div(input logic [1:0] level);
    logic [1:0] result;
    result = 2'd0;
    if (level < 2'd3) result = SPEED_DIV[level];
    return result;
  endfunction

  // Pattern loaded when a mode is entered
  function automatic logic [3:0] mode_load_pattern(input mode_e m);
    logic [3:0] result;
    case (m)
      MODE_RUN, MODE_BOUNCE: result = PAT_FIRST;
      MODE_BLINK:            result = PAT_ALL;
      default:               result = PAT_NONE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_key_filter.sv
// Key conditioning: two-flop synchronizer followed by a saturating
// debounce counter that emits exactly one pulse per press.
module key_filter #(
  parameter logic [19:0] DEB_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag
);

  // One extra bit so the saturation value DEB_MAX+1 always fits
  localparam logic [20:0] DEB_LAST = {1'b0, DEB_MAX};
  localparam logic [20:0] DEB_TOP  = DEB_LAST + 21'd1;

  logic        sync_meta;
  logic        key_sync;
  logic [20:0] deb_cnt;

  // Bring the raw key into the clock domain; idle level is released (1)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_meta <= 1'b1;
      key_sync  <= 1'b1;
    end else begin
      sync_meta <= key_in;
      key_sync  <= sync_meta;
    end
  end

  // Count consecutive low cycles, clearing on any high and holding at the top
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_cnt <= '0;
    end else if (key_sync) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_TOP) begin
      deb_cnt <= deb_cnt + 21'd1;
    end
  end

  // Pulse for the single cycle in which the counter lands on its top value
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_flag <= 1'b0;
    end else begin
      key_flag <= !key_sync && (deb_cnt == DEB_LAST);
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// Four-LED pattern controller with a mode key (RUN/BOUNCE/BLINK/OFF)
// and a speed key selecting one step per 4, 2 or 1 base ticks.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter logic [24:0] CNT_MAX = 25'd24_999_999,
  parameter logic [19:0] DEB_MAX = 20'd999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_mode,
  input  logic       key_speed,
  output logic [3:0] led_out,
  output logic [1:0] mode,
  output logic [1:0] speed
);

  logic        mode_flag;
  logic        speed_flag;
  mode_e       mode_state;
  mode_e       mode_next;
  logic [1:0]  speed_reg;
  logic [24:0] cnt;
  logic        base_tick;
  logic [1:0]  step_cnt;
  logic [1:0]  div;
  logic        step;
  logic [3:0]  pattern;
  logic [3:0]  pattern_next;
  logic        dir;
  logic        dir_next;

  key_filter #(.DEB_MAX(DEB_MAX)) u_mode_key (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_mode),
    .key_flag  (mode_flag)
  );

  key_filter #(.DEB_MAX(DEB_MAX)) u_speed_key (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_speed),
    .key_flag  (speed_flag)
  );

  // Mode state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) mode_state <= MODE_RUN;
    else            mode_state <= mode_next;
  end

  // Next mode: advance cyclically on each mode press
  always_comb begin
    mode_next = mode_state;
    if (mode_flag) mode_next = mode_e'(2'(mode_state + 2'd1));
  end

  // Outputs: LEDs are active-low copies of the pattern register
  always_comb begin
    mode    = mode_state;
    speed   = speed_reg;
    led_out = ~pattern;
  end

  // Speed level cycles 0 -> 1 -> 2 -> 0 on each speed press
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      speed_reg <= 2'd0;
    end else if (speed_flag) begin
      speed_reg <= (speed_reg >= 2'd2) ? 2'd0 : speed_reg + 2'd1;
    end
  end

  // Base tick prescaler; a mode change restarts the timebase
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (mode_flag || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 25'd1;
    end
  end

  // Step generation: a step fires on the base tick where step_cnt has reached div
  always_comb begin
    base_tick = (cnt == CNT_MAX);
    div       = speed_div(speed_reg);
    step      = base_tick && (step_cnt == div);
  end

  // Step divider; either key press restarts the step interval
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      step_cnt <= 2'd0;
    end else if (mode_flag || speed_flag) begin
      step_cnt <= 2'd0;
    end else if (base_tick) begin
      step_cnt <= step ? 2'd0 : step_cnt + 2'd1;
    end
  end

  // Pattern update: a press reloads or discards the step, otherwise animate by mode
  always_comb begin
    pattern_next = pattern;
    dir_next     = dir;
    if (mode_flag) begin
      pattern_next = mode_load_pattern(mode_next);
      dir_next     = 1'b0;
    end else if (step && !speed_flag) begin
      case (mode_state)
        MODE_RUN: begin
          pattern_next = {pattern[2:0], pattern[3]};
        end
        MODE_BOUNCE: begin
          if (!dir) begin
            if (pattern == PAT_LAST) begin
              dir_next     = 1'b1;
              pattern_next = pattern >> 1;
            end else begin
              pattern_next = pattern << 1;
            end
          end else begin
            if (pattern == PAT_FIRST) begin
              dir_next     = 1'b0;
              pattern_next = pattern << 1;
            end else begin
              pattern_next = pattern >> 1;
            end
          end
        end
        MODE_BLINK: begin
          pattern_next = (pattern == PAT_ALL) ? PAT_NONE : PAT_ALL;
        end
        default: begin
          pattern_next = pattern;
        end
      endcase
    end
  end

  // Pattern and bounce direction registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pattern <= PAT_FIRST;
      dir     <= 1'b0;
    end else begin
      pattern <= pattern_next;
      dir     <= dir_next;
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed self-checking bench for led_mode_ctrl with CNT_MAX=3, DEB_MAX=4.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_led_mode_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_mode;
  logic       key_speed;
  logic [3:0] led_out;
  logic [1:0] mode;
  logic [1:0] speed;

  int checks   = 0;
  int failures = 0;

  led_mode_ctrl #(
    .CNT_MAX (25'd3),
    .DEB_MAX (20'd4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_mode  (key_mode),
    .key_speed (key_speed),
    .led_out   (led_out),
    .mode      (mode),
    .speed     (speed)
  );

  // Free-running clock, period 10
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance n rising edges and settle just past the last one
  task automatic waitCycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Hold reset a few cycles, release just after an edge
  task automatic doReset();
    sys_rst_n = 1'b0;
    key_mode  = 1'b1;
    key_speed = 1'b1;
    waitCycles(3);
    sys_rst_n = 1'b1;
  endtask

  // Press the selected keys together; returns just after the edge that applies the press
  task automatic applyStimulus(input logic press_mode, input logic press_speed);
    if (press_mode)  key_mode  = 1'b0;
    if (press_speed) key_speed = 1'b0;
    waitCycles(8);
    key_mode  = 1'b1;
    key_speed = 1'b1;
  endtask

  logic [3:0] bounce_exp [7] = '{4'b1101, 4'b1011, 4'b0111, 4'b1011,
                                 4'b1101, 4'b1110, 4'b1101};

  // Watchdog so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // RUN at speed 0 straight out of reset
    doReset();
    checkOutput("rst_mode", 32'(mode), 32'd0);
    checkOutput("rst_speed", 32'(speed), 32'd0);
    checkOutput("rst_led", 32'(led_out), 32'hE);
    waitCycles(15);
    checkOutput("run_pre_step", 32'(led_out), 32'hE);
    waitCycles(1);
    checkOutput("run_step1", 32'(led_out), 32'hD);
    waitCycles(16);
    checkOutput("run_step2", 32'(led_out), 32'hB);
    waitCycles(16);
    checkOutput("run_step3", 32'(led_out), 32'h7);
    waitCycles(16);
    checkOutput("run_wrap", 32'(led_out), 32'hE);

    // Speed level wraps 0 -> 1 -> 2 -> 0
    doReset();
    applyStimulus(1'b0, 1'b1);
    checkOutput("speed_1", 32'(speed), 32'd1);
    waitCycles(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("speed_2", 32'(speed), 32'd2);
    waitCycles(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("speed_wrap", 32'(speed), 32'd0);
    checkOutput("speed_mode_kept", 32'(mode), 32'd0);

    // BOUNCE at speed 2, then asynchronous reset with dir=1
    doReset();
    applyStimulus(1'b0, 1'b1);
    waitCycles(4);
    applyStimulus(1'b0, 1'b1);
    waitCycles(4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("bounce_mode", 32'(mode), 32'd1);
    checkOutput("bounce_load", 32'(led_out), 32'hE);
    waitCycles(3);
    checkOutput("bounce_pre_step", 32'(led_out), 32'hE);
    waitCycles(1);
    checkOutput("bounce_s1", 32'(led_out), 32'(bounce_exp[0]));
    for (int i = 1; i < 7; i++) begin
      waitCycles(4);
      checkOutput($sformatf("bounce_s%0d", i + 1), 32'(led_out), 32'(bounce_exp[i]));
      if (i == 3) begin
        sys_rst_n = 1'b0;
        #1;
        checkOutput("arst_mode", 32'(mode), 32'd0);
        checkOutput("arst_speed", 32'(speed), 32'd0);
        checkOutput("arst_led", 32'(led_out), 32'hE);
        break;
      end
    end
    waitCycles(1);
    sys_rst_n = 1'b1;
    waitCycles(15);
    checkOutput("post_rst_hold", 32'(led_out), 32'hE);
    waitCycles(1);
    checkOutput("post_rst_s1", 32'(led_out), 32'hD);
    waitCycles(16);
    checkOutput("post_rst_s2", 32'(led_out), 32'hB);

    // Full BOUNCE sequence including the turn back at 0001
    doReset();
    applyStimulus(1'b0, 1'b1);
    waitCycles(4);
    applyStimulus(1'b0, 1'b1);
    waitCycles(4);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      waitCycles(4);
      checkOutput($sformatf("bounce_full_s%0d", i + 1), 32'(led_out), 32'(bounce_exp[i]));
    end

    // Key bounce: short glitches give nothing, a long hold gives one press
    doReset();
    for (int g = 0; g < 3; g++) begin
      key_mode = 1'b0;
      waitCycles(3);
      key_mode = 1'b1;
      waitCycles(3);
    end
    key_mode = 1'b0;
    waitCycles(4);
    key_mode = 1'b1;
    waitCycles(10);
    checkOutput("glitch_no_press", 32'(mode), 32'd0);
    key_mode = 1'b0;
    waitCycles(12);
    key_mode = 1'b1;
    waitCycles(10);
    checkOutput("hold_one_press", 32'(mode), 32'd1);
    waitCycles(20);
    checkOutput("release_no_press", 32'(mode), 32'd1);

    // Both keys on the same cycle
    doReset();
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_mode", 32'(mode), 32'd1);
    checkOutput("both_speed", 32'(speed), 32'd1);
    checkOutput("both_led", 32'(led_out), 32'hE);
    checkOutput("both_cnt", 32'(dut.cnt), 32'd0);

    // Mode cycling through BLINK and OFF back to RUN
    doReset();
    applyStimulus(1'b1, 1'b0);
    checkOutput("cyc_bounce", 32'(mode), 32'd1);
    waitCycles(4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("cyc_blink", 32'(mode), 32'd2);
    checkOutput("blink_load", 32'(led_out), 32'h0);
    waitCycles(15);
    checkOutput("blink_hold", 32'(led_out), 32'h0);
    waitCycles(1);
    checkOutput("blink_s1", 32'(led_out), 32'hF);
    waitCycles(16);
    checkOutput("blink_s2", 32'(led_out), 32'h0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("cyc_off", 32'(mode), 32'd3);
    checkOutput("off_load", 32'(led_out), 32'hF);
    waitCycles(16);
    checkOutput("off_s1", 32'(led_out), 32'hF);
    waitCycles(16);
    checkOutput("off_s2", 32'(led_out), 32'hF);
    applyStimulus(1'b1, 1'b0);
    checkOutput("cyc_run", 32'(mode), 32'd0);
    checkOutput("run_reload", 32'(led_out), 32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
